seq_mult_ctrl: RTL and testbench
================================

# seq_mult_ctrl

Sequencing front end for the unsigned left-shift sequential multiplier. It accepts an operand pair through a start/busy/done/ack handshake and registers the operands. It drives the multiplier's load strobe and counts exactly WIDTH shift cycles, then captures the multiplier's product into a held result register. It sits directly upstream of the multiplier datapath (operand shift registers plus the accumulate stage) and also consumes its product output. It runs on the same divided clk as that datapath.

## Interface
- WIDTH, 6: operand width; product/result width is 2*WIDTH
- clk  in  1  datapath clock (the divided slow clock)
- rst  in  1  synchronous, active-low reset; sampled on posedge clk
- start  in  1  request; accepted only in IDLE
- a  in  WIDTH  multiplicand, sampled on the accepting edge
- b  in  WIDTH  multiplier, sampled on the accepting edge
- ack  in  1  consumer has taken result; honoured only in DONE
- busy  out  1  high in every state except IDLE
- done  out  1  result valid; held until ack
- op_a  out  WIDTH  registered operand to the multiplier's shifting register
- op_b  out  WIDTH  registered operand to the multiplier's fixed register
- mult_load  out  1  load strobe to the multiplier; high for exactly one cycle per operation
- mult_product  in  2*WIDTH  product from the multiplier
- result  out  2*WIDTH  captured product; stable while done=1
- zero_skip  out  1  high with done when the fast path was taken

## Operation
- States: IDLE, LOAD, SHIFT, CAPTURE, DONE.
- IDLE:
  - If start=1 and a≠0 and b≠0: op_a<=a, op_b<=b, go to LOAD.
  - If start=1 and (a==0 or b==0): result<=0, zero_skip<=1, done<=1, go to DONE. This path does not assert mult_load.
- LOAD: mult_load=1 (decoded from state); cnt<=0; go to SHIFT.
- SHIFT:
  - cnt increments every cycle.
  - When cnt==WIDTH-1, go to CAPTURE. This gives exactly WIDTH SHIFT cycles.
  - mult_load=0.
- CAPTURE: result<=mult_product; done<=1; zero_skip<=0; go to DONE.
- DONE:
  - done=1; result held.
  - ack=1: done<=0, go to IDLE.
  - start is ignored in DONE, including when start and ack are asserted together; the consumer must re-raise start in IDLE.
- start in LOAD, SHIFT or CAPTURE is ignored. Operands are not re-sampled.
- Width rules:
  - cnt is clog2(WIDTH)+1 bits; it never wraps within an operation.
  - result is 2*WIDTH bits, unsigned. No overflow is possible: (2^W−1)² < 2^(2W).
- Reset (rst=0 at any edge, including mid-operation):
  - State returns to IDLE.
  - busy=0, done=0, mult_load=0, zero_skip=0.
  - op_a=0, op_b=0, result=0, cnt=0.
  - Any in-flight operation is discarded with no partial result.

## Timing
- Edge E0 accepts start (normal path). LOAD occupies cycle E0–E1, with mult_load high only in that cycle.
- SHIFT occupies E1 to E(1+WIDTH). CAPTURE occupies E(1+WIDTH) to E(2+WIDTH).
- done rises at E(2+WIDTH). For WIDTH=6, done rises at E8: 8 cycles from accept to done.
- Fast path: done and zero_skip rise at E1 (1-cycle latency).
- busy rises at E0 and falls on the edge that samples ack in DONE.
- Minimum repeat interval: next start is accepted one edge after the ack edge. Throughput is WIDTH+4 cycles per operation with ack returned immediately.
- mult_product is sampled only at the CAPTURE→DONE edge. The multiplier must present its final product by then; that is WIDTH cycles after its load.
- result, done and zero_skip are registered. busy and mult_load are state decodes (glitch-free, from the state register only).

## Structure
- Shared package: state encoding constants (IDLE=0, LOAD=1, SHIFT=2, CAPTURE=3, DONE=4, 3-bit), default WIDTH, and a PROD_W = 2*WIDTH constant.
- One sub-module, mult_bit_counter: the cycle counter with clear/enable/terminal-count (tc = cnt==WIDTH-1).
- The FSM and the operand/result registers stay in seq_mult_ctrl.
- The top-level integration wires op_a, op_b and mult_load into the multiplier's operand registers. The clock divider stays outside this block.

## Test plan
- Basic: a=6'd13, b=6'd11, ack held 0.
  - mult_load high in exactly one cycle.
  - done rises 8 cycles after accept; result=12'd143.
  - result is held while ack=0 for 5 more cycles.
- Max operands: a=6'd63, b=6'd63 → result=12'hF81 (3969); zero_skip=0.
- Fast path: a=6'd0, b=6'd45.
  - done and zero_skip rise 1 cycle after accept; result=0.
  - mult_load never asserts.
- Handshake: start held high continuously during an operation with a=5, b=7.
  - Exactly one operation runs; result=35.
  - In DONE, assert start=1 together with ack=1: returns to IDLE with no new operation.
  - The next start edge launches a second one.
- Reset mid-operation: rst=0 during the 3rd SHIFT cycle.
  - Next edge: busy=0, done=0, result=0, op_a=0, op_b=0.
  - A new start with a=2, b=3 then gives result=6 at the normal latency.
- Back-to-back with ack returned immediately: 10 random pairs.
  - Each result matches a*b.
  - Operations are WIDTH+4 cycles apart.

Source files
------------

// File: rtl/seq_mult_ctrl_pkg.sv
// Shared definitions for the sequential multiplier front end: the state
// encoding, the default operand width and the derived product width.
package seq_mult_ctrl_pkg;

    // Default operand width; the product is twice as wide.
    localparam int WIDTH_DEF = 6;
    localparam int PROD_W    = 2 * WIDTH_DEF;

    // Controller states. The encoding is fixed so that anything observing the
    // state register (bench probes, formal checkers) can rely on the values.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Counter width for a WIDTH-cycle shift phase. One extra bit above
    // clog2 keeps the count from wrapping when it steps past WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mult_bit_counter.sv
// Shift-cycle counter for the multiplier sequencer. It is cleared while the
// operands are being loaded, counts once per shift cycle, and flags the last
// shift cycle through tc (count == WIDTH-1).
module mult_bit_counter
    import seq_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,   // synchronous, active low
    input  logic clr,   // force the count to zero
    input  logic en,    // advance the count by one
    output logic tc     // last shift cycle
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over enable, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequencing front end for the unsigned left-shift sequential multiplier.
//
// Handshake: start is sampled only in IDLE; the edge that sees start=1 in
// IDLE accepts a/b. busy is high from that edge until the edge that samples
// ack=1 in DONE. done marks a valid, stable result and stays high until ack;
// ack outside DONE and start outside IDLE are ignored, so a consumer that
// raises start together with ack must raise start again once back in IDLE.
//
// A zero operand takes a fast path straight to DONE with a zero result and
// zero_skip set; the multiplier is never loaded for it. Otherwise the
// operands are registered, mult_load pulses for one cycle, WIDTH shift
// cycles are counted and the multiplier's product is captured.
module seq_mult_ctrl
    import seq_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,          // synchronous, active low
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               ack,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    output logic               mult_load,
    input  logic [2*WIDTH-1:0] mult_product,
    output logic [2*WIDTH-1:0] result,
    output logic               zero_skip
);

    localparam int RES_W = 2 * WIDTH;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_a_d;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] op_b_d;
    logic [RES_W-1:0] result_q;
    logic [RES_W-1:0] result_d;
    logic             done_q;
    logic             done_d;
    logic             zero_skip_q;
    logic             zero_skip_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic             operands_zero;

    // Either operand being zero makes the product zero without running
    // the multiplier.
    assign operands_zero = (a == '0) || (b == '0);

    mult_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    // Next-state and register-update logic; every target defaults to hold.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        result_d    = result_q;
        done_d      = done_q;
        zero_skip_d = zero_skip_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (operands_zero) begin
                        result_d    = '0;
                        zero_skip_d = 1'b1;
                        done_d      = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        op_a_d  = a;
                        op_b_d  = b;
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                // The multiplier loads its operand registers in this cycle;
                // the counter restarts so SHIFT sees 0..WIDTH-1.
                cnt_clr = 1'b1;
                state_d = ST_SHIFT;
            end

            ST_SHIFT: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_d = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                // The multiplier has had WIDTH shift cycles since its load,
                // so its product is final on this edge.
                result_d    = mult_product;
                done_d      = 1'b1;
                zero_skip_d = 1'b0;
                state_d     = ST_DONE;
            end

            ST_DONE: begin
                if (ack) begin
                    done_d      = 1'b0;
                    zero_skip_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            zero_skip_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            result_q    <= result_d;
            done_q      <= done_d;
            zero_skip_q <= zero_skip_d;
        end
    end

    // busy and mult_load decode the state register alone, so they carry no
    // combinational path from the inputs.
    assign busy      = (state_q != ST_IDLE);
    assign mult_load = (state_q == ST_LOAD);

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign result    = result_q;
    assign done      = done_q;
    assign zero_skip = zero_skip_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl. A shift-add multiplier stand-in sits on the
// op_a/op_b/mult_load/mult_product side; expected results come from plain
// a*b arithmetic and expected latencies from the accept/done edge counts.
module tb_seq_mult_ctrl;

    localparam int W  = 6;
    localparam int PW = 2 * W;
    localparam int NORMAL_LAT = W + 2;   // edges from accept to done
    localparam int REPEAT_INT = W + 4;   // accept-to-accept with prompt ack

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          ack;
    logic          busy;
    logic          done;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          mult_load;
    logic [PW-1:0] mult_product;
    logic [PW-1:0] result;
    logic          zero_skip;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [PW-1:0] exp_q[$];

    seq_mult_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .a            (a),
        .b            (b),
        .ack          (ack),
        .busy         (busy),
        .done         (done),
        .op_a         (op_a),
        .op_b         (op_b),
        .mult_load    (mult_load),
        .mult_product (mult_product),
        .result       (result),
        .zero_skip    (zero_skip)
    );

    // Clock and edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier datapath stand-in: loads on mult_load, then one shift-add
    // step per cycle; the product is final W cycles after the load.
    logic [PW-1:0] m_acc = '0;
    logic [PW-1:0] m_sa  = '0;
    logic [W-1:0]  m_sb  = '0;
    always @(posedge clk) begin
        if (mult_load) begin
            m_acc <= '0;
            m_sa  <= {{W{1'b0}}, op_a};
            m_sb  <= op_b;
        end else begin
            if (m_sb[0]) m_acc <= m_acc + m_sa;
            m_sa <= m_sa << 1;
            m_sb <= m_sb >> 1;
        end
    end
    assign mult_product = m_acc;

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and wait for done. lat counts edges after the
    // accepting edge until done is seen; loads counts cycles with mult_load.
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input bit hold_start, output int lat,
                          output int loads, output bit load_e0,
                          output logic [W-1:0] sa, output logic [W-1:0] sb,
                          output bit tmo);
        start = 1'b1;
        a     = ai;
        b     = bi;
        tick();
        load_e0 = mult_load;
        sa      = op_a;
        sb      = op_b;
        loads   = int'(mult_load);
        lat     = 0;
        if (!hold_start) start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
            loads += int'(mult_load);
        end
        tmo = (done !== 1'b1);
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        ack   = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        checks++;
        if ({busy, done, mult_load, zero_skip} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got busy/done/load/zs=%b expected 0000",
                     {busy, done, mult_load, zero_skip});
        end
        checks++;
        if (op_a !== '0 || op_b !== '0 || result !== '0) begin
            failures++;
            $display("FAIL reset_regs: got op_a=%0d op_b=%0d result=%0d expected 0 0 0",
                     op_a, op_b, result);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL ack_release: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, loads;
        bit le0, tmo;
        logic [W-1:0] sa, sb;
        run_op(6'd13, 6'd11, 1'b0, lat, loads, le0, sa, sb, tmo);
        checks++;
        if (tmo || lat != NORMAL_LAT) begin
            failures++;
            $display("FAIL basic_latency: got %0d (timeout=%0b) expected %0d", lat, tmo, NORMAL_LAT);
        end
        checks++;
        if (loads != 1 || le0 !== 1'b1) begin
            failures++;
            $display("FAIL basic_load_pulse: got loads=%0d first=%b expected 1 1", loads, le0);
        end
        checks++;
        if (sa !== 6'd13 || sb !== 6'd11) begin
            failures++;
            $display("FAIL basic_operands: got %0d,%0d expected 13,11", sa, sb);
        end
        checks++;
        if (result !== 12'd143 || zero_skip !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_result: got %0d zs=%b busy=%b expected 143 0 1", result, zero_skip, busy);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (done !== 1'b1 || result !== 12'd143) begin
                failures++;
                $display("FAIL basic_hold: cycle %0d got done=%b result=%0d expected 1 143", i, done, result);
            end
        end
        do_ack();
    endtask

    task automatic test_max();
        int lat, loads;
        bit le0, tmo;
        logic [W-1:0] sa, sb;
        logic [PW-1:0] exp_r;
        exp_r = PW'(63 * 63);
        run_op(6'd63, 6'd63, 1'b0, lat, loads, le0, sa, sb, tmo);
        checks++;
        if (tmo || lat != NORMAL_LAT || result !== exp_r || zero_skip !== 1'b0) begin
            failures++;
            $display("FAIL max_operands: got lat=%0d result=%h zs=%b expected %0d %h 0",
                     lat, result, zero_skip, NORMAL_LAT, exp_r);
        end
        do_ack();
    endtask

    task automatic test_fast_path();
        int lat, loads;
        bit le0, tmo;
        logic [W-1:0] sa, sb;
        logic [W-1:0] ra;
        run_op(6'd0, 6'd45, 1'b0, lat, loads, le0, sa, sb, tmo);
        checks++;
        if (tmo || lat != 0 || zero_skip !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL fast_timing: got lat=%0d zs=%b busy=%b expected 0 1 1", lat, zero_skip, busy);
        end
        checks++;
        if (result !== '0 || loads != 0) begin
            failures++;
            $display("FAIL fast_result: got result=%0d loads=%0d expected 0 0", result, loads);
        end
        do_ack();
        checks++;
        if (zero_skip !== 1'b0) begin
            failures++;
            $display("FAIL fast_zs_clear: got %b expected 0", zero_skip);
        end
        ra = W'($urandom_range(1, 63));
        run_op(ra, 6'd0, 1'b0, lat, loads, le0, sa, sb, tmo);
        checks++;
        if (tmo || lat != 0 || zero_skip !== 1'b1 || result !== '0 || loads != 0) begin
            failures++;
            $display("FAIL fast_b_zero: got lat=%0d zs=%b result=%0d loads=%0d expected 0 1 0 0",
                     lat, zero_skip, result, loads);
        end
        do_ack();
    endtask

    task automatic test_handshake();
        int lat, loads;
        bit le0, tmo;
        logic [W-1:0] sa, sb;
        run_op(6'd5, 6'd7, 1'b1, lat, loads, le0, sa, sb, tmo);
        checks++;
        if (tmo || lat != NORMAL_LAT || loads != 1 || result !== 12'd35) begin
            failures++;
            $display("FAIL hs_held_start: got lat=%0d loads=%0d result=%0d expected %0d 1 35",
                     lat, loads, result, NORMAL_LAT);
        end
        // start and ack together in DONE: only the ack takes effect
        start = 1'b1;
        ack   = 1'b1;
        tick();
        start = 1'b0;
        ack   = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mult_load !== 1'b0) begin
            failures++;
            $display("FAIL hs_start_ack: got busy=%b done=%b load=%b expected 0 0 0", busy, done, mult_load);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL hs_no_relaunch: got busy=%b expected 0", busy);
        end
        run_op(6'd9, 6'd4, 1'b0, lat, loads, le0, sa, sb, tmo);
        checks++;
        if (tmo || lat != NORMAL_LAT || result !== 12'd36) begin
            failures++;
            $display("FAIL hs_second_op: got lat=%0d result=%0d expected %0d 36", lat, result, NORMAL_LAT);
        end
        do_ack();
    endtask

    task automatic test_reset_mid_op();
        int lat, loads;
        bit le0, tmo;
        logic [W-1:0] sa, sb;
        start = 1'b1;
        a     = 6'd37;
        b     = 6'd21;
        tick();              // accept: LOAD
        start = 1'b0;
        tick();              // first shift cycle
        tick();              // second shift cycle
        tick();              // third shift cycle
        rst = 1'b0;
        tick();
        checks++;
        if ({busy, done, mult_load, zero_skip} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_flags: got busy/done/load/zs=%b expected 0000",
                     {busy, done, mult_load, zero_skip});
        end
        checks++;
        if (result !== '0 || op_a !== '0 || op_b !== '0) begin
            failures++;
            $display("FAIL midrst_regs: got result=%0d op_a=%0d op_b=%0d expected 0 0 0",
                     result, op_a, op_b);
        end
        rst = 1'b1;
        tick();
        run_op(6'd2, 6'd3, 1'b0, lat, loads, le0, sa, sb, tmo);
        checks++;
        if (tmo || lat != NORMAL_LAT || result !== 12'd6 || loads != 1) begin
            failures++;
            $display("FAIL midrst_restart: got lat=%0d result=%0d loads=%0d expected %0d 6 1",
                     lat, result, loads, NORMAL_LAT);
        end
        do_ack();
    endtask

    task automatic test_back_to_back();
        int prev_acc;
        int acc_cyc;
        int wait_n;
        logic [W-1:0] ra, rb;
        logic [PW-1:0] exp_r;
        prev_acc = 0;
        for (int i = 0; i < 10; i++) begin
            ra = W'($urandom_range(1, 63));
            rb = W'($urandom_range(1, 63));
            exp_q.push_back(PW'(int'(ra) * int'(rb)));
            start = 1'b1;
            a     = ra;
            b     = rb;
            tick();
            acc_cyc = cyc;
            start = 1'b0;
            if (i > 0) begin
                checks++;
                if (acc_cyc - prev_acc != REPEAT_INT) begin
                    failures++;
                    $display("FAIL b2b_interval: op %0d got %0d expected %0d", i, acc_cyc - prev_acc, REPEAT_INT);
                end
            end
            prev_acc = acc_cyc;
            wait_n = 0;
            while (done !== 1'b1 && wait_n < 40) begin
                tick();
                wait_n++;
            end
            exp_r = exp_q.pop_front();
            checks++;
            if (done !== 1'b1 || result !== exp_r) begin
                failures++;
                $display("FAIL b2b_result: op %0d (%0d*%0d) got %0d done=%b expected %0d",
                         i, ra, rb, result, done, exp_r);
            end
            ack = 1'b1;
            tick();
            ack = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_fast_path();
        test_handshake();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
